// File: rtl/add_seq_ctrl_if.sv
// Operand/result handshake bundle for the byte-serial adder sequencer.
// slave is the sequencer's view, master is the producer/consumer view.
interface add_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/add_seq_ctrl.sv
// Byte-serial WIDTH-bit adder: one 8-bit slice per cycle, LSB first,
// with a registered carry linking the slices.
//
// state  | meaning
// IDLE   | ready for operands, no result pending
// RUN    | adding slice r_idx, one byte per cycle
// DONE   | result held on sum/cout until out_ready
module add_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  add_seq_ctrl_if.slave bus
);
  localparam int NSLICE = WIDTH / 8;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_sum;

  logic             w_accept;
  logic             w_last;
  logic [IDXW+2:0]  w_base;
  logic [8:0]       w_slice;

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;
  assign w_last   = (r_idx == LAST_IDX);
  assign w_base   = {r_idx, 3'b000};
  assign w_slice  = {1'b0, r_a[w_base +: 8]} + {1'b0, r_b[w_base +: 8]} + {8'd0, r_carry};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_idx   <= '0;
            r_sum   <= '0;
          end
        end
        S_RUN: begin
          r_sum[w_base +: 8] <= w_slice[7:0];
          r_carry            <= w_slice[8];
          if (!w_last) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decode only the registered state; no input feeds them.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    bus.sum       = r_sum;
    bus.cout      = r_carry;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
      end
      S_DONE:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Randomized and directed checks of add_seq_ctrl against a plain
// arithmetic reference ({cout,sum} = a+b+cin, latency WIDTH/8).
module tb_add_seq_ctrl;
  localparam int WIDTH  = 32;
  localparam int NSLICE = WIDTH / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  add_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  add_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic cin);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 1);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 0);
    chk({tag, "_busy"}, 64'(bus.busy), 0);
  endtask

  // One full transaction: accept, count latency, optional back-pressure, release.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic cin, input int hold);
    logic [WIDTH:0] exp;
    int cycles;
    int guard;
    exp = ref_add(a, b, cin);
    guard = 0;
    while (!bus.in_ready && guard < 20) begin step(); guard++; end
    if (!bus.in_ready) chk({tag, "_wait_ready_timeout"}, 1, 0);
    bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.cin = cin;
    step();
    bus.in_valid = 1'b0;
    bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.cin = 1'($urandom);
    cycles = 0;
    while (!bus.out_valid && cycles < NSLICE + 10) begin
      if (bus.in_ready !== 1'b0) chk({tag, "_in_ready_run"}, 64'(bus.in_ready), 0);
      step();
      cycles++;
    end
    chk({tag, "_latency"}, 64'(cycles), 64'(NSLICE));
    chk({tag, "_result"}, 64'({bus.cout, bus.sum}), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = ~bus.in_valid;
      step();
      chk({tag, "_hold_valid"}, 64'(bus.out_valid), 1);
      chk({tag, "_hold_result"}, 64'({bus.cout, bus.sum}), 64'(exp));
      chk({tag, "_hold_in_ready"}, 64'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    // in_valid was high through the handshake edge: must land in IDLE, not RUN
    chk_idle({tag, "_after_hs"});
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [WIDTH:0] exp;
    logic [WIDTH:0] q[$];
    int last_acc;
    int n_res;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0;

    rst_n = 1'b0;
    step();
    chk_idle("por");
    chk("por_sum", 64'(bus.sum), 0);
    chk("por_cout", 64'(bus.cout), 0);
    rst_n = 1'b1;
    step();

    // reset from an in-flight state, held for two cycles
    bus.in_valid = 1'b1; bus.a = 32'hDEAD_BEEF; bus.b = 32'hFFFF_0000; bus.cin = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    chk_idle("rst1");
    chk("rst1_sum", 64'(bus.sum), 0);
    chk("rst1_cout", 64'(bus.cout), 0);
    step();
    chk_idle("rst2");
    rst_n = 1'b1;
    step();

    run_op("xcarry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
    chk("xcarry_sum", 64'(bus.sum), 64'h0000_0100);
    run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
    run_op("bpress", 32'h1234_5678, 32'h1111_1111, 1'b0, 5);

    // reset while the idx==2 slice would be computed
    bus.in_valid = 1'b1; bus.a = 32'hFFFF_FFFF; bus.b = 32'h0000_0001; bus.cin = 1'b0;
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_idle("midrun_rst");
    chk("midrun_sum", 64'(bus.sum), 0);
    for (int i = 0; i < NSLICE + 2; i++) begin
      step();
      if (bus.out_valid !== 1'b0) chk("midrun_ghost_valid", 64'(bus.out_valid), 0);
    end
    bus.out_ready = 1'b0;
    run_op("after_rst", 32'h8000_0000, 32'h8000_0000, 1'b0, 0);

    for (int k = 0; k < 12; k++)
      run_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    run_op("max", '1, '1, 1'b1, 1);

    // streaming: operands change every cycle, only accepted sets count
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.cin = 1'($urandom);
    last_acc = -1;
    n_res = 0;
    for (int cyc = 0; cyc < 400 && n_res < 20; cyc++) begin
      if (bus.out_valid) begin
        if (q.size() == 0) chk("stream_spurious_valid", 1, 0);
        else begin
          exp = q.pop_front();
          chk("stream_result", 64'({bus.cout, bus.sum}), 64'(exp));
          n_res++;
        end
      end
      if (bus.in_ready) begin
        q.push_back(ref_add(bus.a, bus.b, bus.cin));
        if (last_acc >= 0) chk("stream_period", 64'(cyc - last_acc), 64'(NSLICE + 2));
        last_acc = cyc;
      end
      step();
      bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.cin = 1'($urandom);
    end
    if (n_res < 20) chk("stream_timeout", 64'(n_res), 20);
    bus.in_valid = 1'b0;
    repeat (NSLICE + 3) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
